// File: rtl/path_result_display_pkg.sv
// path_display_pkg: shared constants and the FSM state encoding for
// path_result_display.
//   RESULT_ADDR_DEF / DONE_ADDR_DEF : default mailbox addresses
//   EMPTY_CODE                      : LED pattern shown when a run captured nothing
//   state_t                         : IDLE, CAPTURE, SHOW, GAP (2-bit)
package path_display_pkg;

  localparam logic [31:0] RESULT_ADDR_DEF = 32'h0200_0000;
  localparam logic [31:0] DONE_ADDR_DEF   = 32'h0200_0008;
  localparam logic [3:0]  EMPTY_CODE      = 4'hF;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    SHOW    = 2'd2,
    GAP     = 2'd3
  } state_t;

endpackage

// File: rtl/path_result_display_dwell_timer.sv
// dwell_timer: interval timer used for both the LED dwell and the blank gap.
// A value of 0 marks the first cycle of an interval; tc pulses on the last
// cycle of each LEN-cycle interval while en is held, after which the counter
// is back at 0 ready for the next interval.
//   clk     : system clock
//   reset   : synchronous, active-high
//   restart : synchronous return to the start of an interval
//   en      : count this cycle
//   tc      : terminal-count pulse (last cycle of the interval)
module dwell_timer #(
  parameter int unsigned LEN = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  input  logic en,
  output logic tc
);

  localparam int unsigned W = $clog2(LEN) + 1;

  logic [W-1:0] value;

  // Loaded with LEN-1 on the first cycle, so reaching 1 marks the last cycle.
  // A one-cycle interval never leaves 0 and terminates every enabled cycle.
  assign tc = en && ((LEN == 1) || (value == W'(1)));

  always_ff @(posedge clk) begin
    if (reset || restart) begin
      value <= '0;
    end else if (en) begin
      value <= (value == '0) ? W'(LEN - 1) : value - W'(1);
    end
  end

endmodule

// File: rtl/path_result_display.sv
// path_result_display: snoops CPU data-memory stores, captures node IDs
// written to RESULT_ADDR, and after a DONE_ADDR store cycles the captured
// IDs on the board LEDs with a fixed dwell per entry.
//   clk, reset (sync, active-high), clear (one-cycle restart pulse)
//   MemWrite, DataAdr, WriteData : CPU store bus
//   led      : displayed node ID (0 outside SHOW, EMPTY_CODE for an empty run)
//   count    : entries captured
//   done     : end-of-run store seen, buffer frozen
//   overflow : sticky, a result store arrived with the buffer full
// Optional macro BLINK_GAP_EN: blank the LEDs for GAP_CYCLES after every dwell.
module path_result_display
  import path_display_pkg::*;
#(
  parameter int unsigned DEPTH        = 16,
  parameter int unsigned DATA_W       = 4,
  parameter int unsigned DWELL_CYCLES = 2000000,
  parameter int unsigned GAP_CYCLES   = 200000,
  parameter logic [31:0] RESULT_ADDR  = RESULT_ADDR_DEF,
  parameter logic [31:0] DONE_ADDR    = DONE_ADDR_DEF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clear,
  input  logic                       MemWrite,
  input  logic [31:0]                DataAdr,
  input  logic [31:0]                WriteData,
  output logic [DATA_W-1:0]          led,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       done,
  output logic                       overflow
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  state_t            state, state_next;
  logic [DATA_W-1:0] result_mem [DEPTH];
  logic [PW-1:0]     wptr, rptr;
  logic              hit_result, hit_done, accepting, go_show, store_ok;
  logic              has_entries, last_entry, dwell_en, dwell_tc, advance;
  logic              unused_bits;

  assign hit_result  = MemWrite && (DataAdr == RESULT_ADDR);
  assign hit_done    = MemWrite && (DataAdr == DONE_ADDR);
  assign accepting   = ((state == IDLE) || (state == CAPTURE)) && !done;
  assign go_show     = accepting && hit_done;
  assign store_ok    = accepting && hit_result && (count < CW'(DEPTH));
  assign has_entries = (count != '0);
  assign last_entry  = ({1'b0, rptr} == count - CW'(1));
  assign dwell_en    = (state == SHOW) && has_entries;
  assign unused_bits = ^WriteData[31:DATA_W];

  dwell_timer #(.LEN(DWELL_CYCLES)) u_dwell (
    .clk     (clk),
    .reset   (reset),
    .restart (clear || go_show),
    .en      (dwell_en),
    .tc      (dwell_tc)
  );

`ifdef BLINK_GAP_EN
  logic gap_tc;

  dwell_timer #(.LEN(GAP_CYCLES)) u_gap (
    .clk     (clk),
    .reset   (reset),
    .restart (clear),
    .en      (state == GAP),
    .tc      (gap_tc)
  );

  // The next entry is selected at the end of the gap, so SHOW resumes on it.
  assign advance = gap_tc;
`else
  logic unused_gap;
  assign unused_gap = ^GAP_CYCLES;
  assign advance    = dwell_tc;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    led        = '0;
    case (state)
      IDLE: begin
        if (go_show) begin
          state_next = SHOW;
        end else if (accepting && hit_result) begin
          state_next = CAPTURE;
        end
      end
      CAPTURE: begin
        if (go_show) begin
          state_next = SHOW;
        end
      end
      SHOW: begin
        led = has_entries ? result_mem[rptr] : DATA_W'(EMPTY_CODE);
`ifdef BLINK_GAP_EN
        if (dwell_tc) begin
          state_next = GAP;
        end
`endif
      end
      GAP: begin
`ifdef BLINK_GAP_EN
        if (gap_tc) begin
          state_next = SHOW;
        end
`endif
      end
      default: state_next = IDLE;
    endcase
    if (clear) begin
      state_next = IDLE;
    end
  end

  // Buffer storage carries no reset; count/wptr define which entries are valid.
  always_ff @(posedge clk) begin
    if (!reset && !clear && store_ok) begin
      result_mem[wptr] <= WriteData[DATA_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      done     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (accepting && hit_result) begin
        if (store_ok) begin
          wptr  <= wptr + PW'(1);
          count <= count + CW'(1);
        end else begin
          overflow <= 1'b1;
        end
      end
      if (go_show) begin
        done <= 1'b1;
        rptr <= '0;
      end else if (advance) begin
        rptr <= last_entry ? '0 : rptr + PW'(1);
      end
    end
  end

endmodule

// File: tb/tb_path_result_display.sv
module tb_path_result_display;

  localparam int DEPTH = 16;
  localparam int DWELL = 4;
  localparam int GAPC  = 2;
  localparam logic [31:0] RES   = 32'h0200_0000;
  localparam logic [31:0] DONEA = 32'h0200_0008;
`ifdef BLINK_GAP_EN
  localparam int GAPLEN = GAPC;
`else
  localparam int GAPLEN = 0;
`endif

  logic        clk = 1'b0;
  logic        reset, clear, MemWrite;
  logic [31:0] DataAdr, WriteData;
  logic [3:0]  led;
  logic [4:0]  count;
  logic        done, overflow;

  path_result_display #(
    .DEPTH(DEPTH), .DATA_W(4), .DWELL_CYCLES(DWELL), .GAP_CYCLES(GAPC),
    .RESULT_ADDR(RES), .DONE_ADDR(DONEA)
  ) dut (
    .clk(clk), .reset(reset), .clear(clear), .MemWrite(MemWrite),
    .DataAdr(DataAdr), .WriteData(WriteData), .led(led), .count(count),
    .done(done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model of what the block should have captured.
  logic [3:0] m_buf[$];
  bit         m_done, m_ovf;
  logic [3:0] exp_q[$];

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] data;
    int          exp_count;
    logic        exp_done;
  } vec_t;
  vec_t vt[8];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    m_buf.delete();
    m_done = 0;
    m_ovf  = 0;
  endtask

  task automatic store(input logic we, input logic [31:0] adr, input logic [31:0] data);
    MemWrite  = we;
    DataAdr   = adr;
    WriteData = data;
    tick();
    MemWrite  = 1'b0;
    if (we && !m_done) begin
      if (adr == RES) begin
        if (m_buf.size() < DEPTH) m_buf.push_back(data[3:0]);
        else m_ovf = 1;
      end else if (adr == DONEA) begin
        m_done = 1;
      end
    end
    chk("store_count", int'(count), m_buf.size());
    chk("store_done", int'(done), int'(m_done));
    chk("store_overflow", int'(overflow), int'(m_ovf));
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    model_clear();
  endtask

  // Expected LED stream from display cycle 'start' onward, pushed up front and
  // popped one per cycle as the DUT drives it.
  task automatic check_display(input string name, input int start, input int cycles);
    int n;
    int period;
    n = m_buf.size();
    period = DWELL + GAPLEN;
    for (int k = start; k < start + cycles; k++) begin
      if (n == 0) exp_q.push_back(4'hF);
      else if ((k % period) < DWELL) exp_q.push_back(m_buf[(k / period) % n]);
      else exp_q.push_back(4'h0);
    end
    while (exp_q.size() > 0) begin
      chk(name, int'(led), int'(exp_q.pop_front()));
      tick();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; clear = 1'b0; MemWrite = 1'b0; DataAdr = '0; WriteData = '0;
    model_clear();
    repeat (3) tick();
    reset = 1'b0;
    chk("reset_led", int'(led), 0);
    chk("reset_count", int'(count), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_overflow", int'(overflow), 0);

    // Basic run: 3, 7, 2 then done.
    store(1, RES, 3);
    chk("capture_led_dark", int'(led), 0);
    store(1, RES, 7);
    store(1, RES, 2);
    store(1, DONEA, 0);
    check_display("basic_led", 0, 3 * (DWELL + GAPLEN) + DWELL + 1);

    // Filtering and post-done stores, table-driven.
    do_clear();
    vt[0] = '{1'b1, 32'h0200_0004, 32'd5, 0, 1'b0};
    vt[1] = '{1'b1, 32'h0000_0000, 32'd5, 0, 1'b0};
    vt[2] = '{1'b0, RES,           32'd5, 0, 1'b0};
    vt[3] = '{1'b1, RES,           32'd1, 1, 1'b0};
    vt[4] = '{1'b1, 32'h0200_0004, 32'd8, 1, 1'b0};
    vt[5] = '{1'b1, DONEA,         32'd0, 1, 1'b1};
    vt[6] = '{1'b1, RES,           32'd4, 1, 1'b1};
    vt[7] = '{1'b1, DONEA,         32'd0, 1, 1'b1};
    for (int i = 0; i < 8; i++) begin
      store(vt[i].we, vt[i].adr, vt[i].data);
      chk($sformatf("vec%0d_count", i), int'(count), vt[i].exp_count);
      chk($sformatf("vec%0d_done", i), int'(done), int'(vt[i].exp_done));
    end
    check_display("single_led", 2, 3 * (DWELL + GAPLEN));

    // Overflow: 18 stores into a 16-entry buffer.
    do_clear();
    for (int i = 0; i < 18; i++) store(1, RES, i);
    chk("ovf_count", int'(count), 16);
    chk("ovf_flag", int'(overflow), 1);
    store(1, DONEA, 0);
    check_display("ovf_led", 0, 16 * (DWELL + GAPLEN) + DWELL);

    // Clear mid-display with a simultaneous result store.
    clear = 1'b1; MemWrite = 1'b1; DataAdr = RES; WriteData = 32'd9;
    tick();
    clear = 1'b0; MemWrite = 1'b0;
    model_clear();
    chk("clr_led", int'(led), 0);
    chk("clr_count", int'(count), 0);
    chk("clr_done", int'(done), 0);
    chk("clr_overflow", int'(overflow), 0);
    tick();
    chk("clr_count_later", int'(count), 0);
    store(1, RES, 5);
    chk("clr_then_capture_led", int'(led), 0);

    // Empty run.
    do_clear();
    store(1, DONEA, 0);
    check_display("empty_led", 0, 20);
    chk("empty_count", int'(count), 0);

    // Equal consecutive IDs (separated only when the gap is enabled).
    do_clear();
    store(1, RES, 6);
    store(1, RES, 6);
    store(1, DONEA, 0);
    check_display("gap_led", 0, 3 * (DWELL + GAPLEN));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
